muldiv_unit: RTL

- Iterative RV32M multiply/divide engine in the EX stage, directly upstream of the EX/MEM pipeline register.
- Accepts one M-extension op from the ID/EX register and holds the pipeline stalled while it iterates.
- Presents the result and destination register in the cycle the EX/MEM register captures it; drives the ex_is_muldiv path.

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage: radix-2 shift-add
// multiply and restoring divide on operand magnitudes, one step per cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            is_muldiv
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              r_state;
   logic [2:0]          r_op;
   logic [4:0]          r_rd;
   logic [CW-1:0]       r_cnt;
   logic [XLEN-1:0]     r_a;
   logic [2*XLEN-1:0]   r_prod;
   logic [XLEN-1:0]     r_quo;
   logic [XLEN-1:0]     r_rem;
   logic                r_negQ;
   logic                r_negR;
   logic                r_done;
   logic [XLEN-1:0]     r_result;
   logic [4:0]          r_rdOut;

   logic                w_accept;
   logic                w_aSigned;
   logic                w_bSigned;
   logic                w_aNeg;
   logic                w_bNeg;
   logic [XLEN-1:0]     w_aMag;
   logic [XLEN-1:0]     w_bMag;
   logic                w_divZero;
   logic                w_divOvf;
   logic [XLEN:0]       w_mulSum;
   logic [2*XLEN-1:0]   w_prodNext;
   logic [XLEN:0]       w_trial;
   logic                w_fits;
   logic [XLEN-1:0]     w_quoNext;
   logic [XLEN-1:0]     w_remNext;
   logic [2*XLEN-1:0]   w_prodFinal;
   logic [XLEN-1:0]     w_quoFinal;
   logic [XLEN-1:0]     w_remFinal;
   logic [XLEN-1:0]     w_result;

   assign w_accept  = (r_state == IDLE) && start && !kill;
   assign w_aSigned = op[2] ? !op[0] : (op[1:0] != 2'b11);
   assign w_bSigned = op[2] ? !op[0] : (op[1:0] < 2'd2);
   assign w_aNeg    = w_aSigned && rs1_val[XLEN-1];
   assign w_bNeg    = w_bSigned && rs2_val[XLEN-1];
   assign w_aMag    = w_aNeg ? -rs1_val : rs1_val;
   assign w_bMag    = w_bNeg ? -rs2_val : rs2_val;
   assign w_divZero = op[2] && (rs2_val == '0);
   assign w_divOvf  = op[2] && !op[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);

   // Multiplier sits in the low half of r_prod and shifts out as partial sums shift in.
   assign w_mulSum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
   assign w_prodNext = {w_mulSum, r_prod[XLEN-1:1]};

   // Dividend shifts out of r_quo into the partial remainder; quotient bits shift in behind it.
   assign w_trial   = {r_rem, r_quo[XLEN-1]} - {1'b0, r_a};
   assign w_fits    = !w_trial[XLEN];
   assign w_remNext = w_fits ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
   assign w_quoNext = {r_quo[XLEN-2:0], w_fits};

   assign w_prodFinal = r_negQ ? -w_prodNext : w_prodNext;
   assign w_quoFinal  = r_negQ ? -w_quoNext : w_quoNext;
   assign w_remFinal  = r_negR ? -w_remNext : w_remNext;

   always_comb begin
      w_result = w_quoFinal;
      case (r_op)
         3'd0:             w_result = w_prodFinal[XLEN-1:0];
         3'd1, 3'd2, 3'd3: w_result = w_prodFinal[2*XLEN-1:XLEN];
         3'd6, 3'd7:       w_result = w_remFinal;
         default:          w_result = w_quoFinal;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_rd     <= '0;
         r_cnt    <= '0;
         r_a      <= '0;
         r_prod   <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_negQ   <= 1'b0;
         r_negR   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_rdOut  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op   <= op;
                  r_rd   <= rd_in;
                  r_negQ <= w_aNeg ^ w_bNeg;
                  r_negR <= w_aNeg;
                  r_a    <= op[2] ? w_bMag : w_aMag;
                  r_prod <= {{XLEN{1'b0}}, w_bMag};
                  r_quo  <= w_aMag;
                  r_rem  <= '0;
                  r_cnt  <= CW'(XLEN - 1);
                  if (w_divZero) begin
                     r_result <= op[1] ? rs1_val : '1;
                     r_rdOut  <= rd_in;
                     r_done   <= 1'b1;
                     r_state  <= DONE;
                  end else if (w_divOvf) begin
                     r_result <= op[1] ? '0 : rs1_val;
                     r_rdOut  <= rd_in;
                     r_done   <= 1'b1;
                     r_state  <= DONE;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (kill) begin
                  r_state <= IDLE;
               end else begin
                  if (r_op[2]) begin
                     r_quo <= w_quoNext;
                     r_rem <= w_remNext;
                  end else begin
                     r_prod <= w_prodNext;
                  end
                  if (r_cnt == '0) begin
                     r_result <= w_result;
                     r_rdOut  <= r_rd;
                     r_done   <= 1'b1;
                     r_state  <= DONE;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
            end
            // DONE always returns to IDLE; its instruction leaves EX on this edge.
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stall     = w_accept || (r_state == RUN);
   assign done      = r_done;
   assign is_muldiv = r_done;
   assign result    = r_result;
   assign rd_out    = r_rdOut;

endmodule
